// File: rtl/issue_scoreboard_pkg.sv
// Shared constants for the issue scoreboard: pipe indices, default latencies
// and the variable-latency pipe state encoding.
package issue_scoreboard_pkg;

    localparam int DEF_NUM_PIPES = 4;
    localparam int DEF_MAX_LAT   = 8;
    localparam int LAT_W         = 8;

    localparam int PIPE_L1  = 0;
    localparam int PIPE_L2  = 1;
    localparam int PIPE_VAR = 2;
    localparam int PIPE_L3  = 3;

    // One LAT_W field per pipe, pipe 3 in the top field; 0 marks the variable pipe.
    localparam logic [DEF_NUM_PIPES*LAT_W-1:0] DEF_PIPE_LAT = {8'd3, 8'd0, 8'd2, 8'd1};

    typedef enum logic {
        VAR_IDLE = 1'b0,
        VAR_BUSY = 1'b1
    } var_state_e;

endpackage

// File: rtl/issue_scoreboard_wb_slot_tracker.sv
// Write-back slot reservation shifter: resv[k] set means the WB port is taken
// k cycles from now.
module wb_slot_tracker #(
    parameter int MAX_LAT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MAX_LAT-1:1] reserve,
    output logic [MAX_LAT:1]   resv
);

    logic [MAX_LAT:1] resv_q;
    logic [MAX_LAT:1] resv_d;

    // The top slot is never reserved: a latency-L issue lands in slot L-1 next cycle.
    always_comb begin
        resv_d = '0;
        for (int k = 1; k < MAX_LAT; k++) begin
            resv_d[k] = resv_q[k+1] | reserve[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resv_q <= '0;
        end else begin
            resv_q <= resv_d;
        end
    end

    assign resv = resv_q;

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: register pending bits, WB-port slot reservation
// and arbitration of the single variable-latency pipe.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int                         NUM_REGS         = 32,
    parameter int                         NUM_PIPES        = DEF_NUM_PIPES,
    parameter int                         MAX_LAT          = DEF_MAX_LAT,
    parameter logic [NUM_PIPES*LAT_W-1:0] PIPE_LAT         = DEF_PIPE_LAT,
    parameter int                         VAR_PIPE         = PIPE_VAR,
    parameter bit                         ENABLE_BYPASS_WB = 1'b1,
    localparam int                        REG_W            = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [NUM_PIPES-1:0] id_pipe,
    input  logic [REG_W-1:0]     id_rd,
    input  logic [REG_W-1:0]     id_rs1,
    input  logic [REG_W-1:0]     id_rs2,
    input  logic                 id_rd_we,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic                 wb_en,
    input  logic [REG_W-1:0]     wb_rd,
    input  logic                 var_done,
    output logic                 var_wb_grant,
    output logic                 issue,
    output logic                 sb_conflict,
    output logic                 wb_conflict,
    output logic                 var_busy,
    output logic [NUM_REGS-1:0]  pending
);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    var_state_e          state_q, state_d;
    logic [MAX_LAT:1]    resv;
    logic [MAX_LAT-1:1]  reserve;
    logic [LAT_W-1:0]    id_lat;
    logic                sb_raw, wb_raw, grant_raw;

    function automatic logic operand_blocked(
        input logic [NUM_REGS-1:0] pend,
        input logic                used,
        input logic [REG_W-1:0]    r,
        input logic                wb_valid,
        input logic [REG_W-1:0]    wb_reg
    );
        logic bypass;
        bypass = ENABLE_BYPASS_WB && wb_valid && (wb_reg == r);
        return used && (r != '0) && pend[r] && !bypass;
    endfunction

    always_comb begin
        id_lat = '0;
        for (int p = 0; p < NUM_PIPES; p++) begin
            if (id_pipe[p]) begin
                id_lat = id_lat | PIPE_LAT[p*LAT_W +: LAT_W];
            end
        end
    end

    assign grant_raw = var_done && (state_q == VAR_BUSY) && !resv[1];

    always_comb begin
        sb_raw = operand_blocked(pending_q, id_rs1_used, id_rs1, wb_en, wb_rd)
               | operand_blocked(pending_q, id_rs2_used, id_rs2, wb_en, wb_rd)
               | operand_blocked(pending_q, id_rd_we,    id_rd,  wb_en, wb_rd);
        // Single-cycle pipes write back in the slot the variable result was just granted.
        wb_raw = (id_lat == LAT_W'(1)) && grant_raw;
        for (int k = 2; k <= MAX_LAT; k++) begin
            if (id_rd_we && (id_lat == LAT_W'(k)) && resv[k]) begin
                wb_raw = 1'b1;
            end
        end
    end

    // Every output is forced low while reset is held, independent of the inputs.
    assign sb_conflict  = sb_raw && !rst;
    assign wb_conflict  = wb_raw && !rst;
    assign var_busy     = (state_q == VAR_BUSY) && !rst;
    assign var_wb_grant = grant_raw && !rst;
    assign issue        = id_valid && !stall && !flush && !sb_conflict && !wb_conflict
                          && !(var_busy && id_pipe[VAR_PIPE]) && !rst;

    genvar gi;
    generate
        for (gi = 1; gi < MAX_LAT; gi++) begin : g_reserve
            assign reserve[gi] = issue && id_rd_we && (id_lat == LAT_W'(gi + 1));
        end
    endgenerate

    wb_slot_tracker #(
        .MAX_LAT (MAX_LAT)
    ) u_wb_slot_tracker (
        .clk     (clk),
        .rst     (rst),
        .reserve (reserve),
        .resv    (resv)
    );

    always_comb begin
        pending_d = pending_q;
        if (wb_en) begin
            pending_d[wb_rd] = 1'b0;
        end
        if (issue && id_rd_we && (id_rd != '0)) begin
            pending_d[id_rd] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            VAR_IDLE: if (issue && id_pipe[VAR_PIPE]) state_d = VAR_BUSY;
            VAR_BUSY: if (grant_raw)                  state_d = VAR_IDLE;
            default:                                  state_d = VAR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            state_q   <= VAR_IDLE;
        end else begin
            pending_q <= pending_d;
            state_q   <= state_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, architectural register count; REG_W = $clog2(NUM_REGS).
REQ-002 SHALL have parameter NUM_PIPES, default 4, number of execution pipes.
REQ-003 SHALL have parameter MAX_LAT, default 8, largest fixed pipe latency in cycles.
REQ-004 SHALL have parameter PIPE_LAT, default {3,0,2,1} (pipe 3..0), per-pipe fixed latency 1..MAX_LAT; 0 marks the variable-latency pipe.
REQ-005 SHALL have parameter VAR_PIPE, default 2, index of the single variable-latency pipe.
REQ-006 SHALL have parameter ENABLE_BYPASS_WB, default 1, which permits a same-cycle WB write to satisfy a source or destination dependency.
REQ-007 clk  in  1  clock; all state updates on the rising edge.
REQ-008 rst  in  1  reset, asynchronous and active-high.
REQ-009 stall  in  1  downstream hold; no issue is allowed.
REQ-010 flush  in  1  squashes the current ID instruction; no issue is allowed.
REQ-011 id_valid  in  1  ID presents an instruction.
REQ-012 id_pipe  in  NUM_PIPES  one-hot target pipe.
REQ-013 id_rd, id_rs1, id_rs2  in  REG_W each  destination and source register indices.
REQ-014 id_rd_we, id_rs1_used, id_rs2_used  in  1 each  operand-use qualifiers.
REQ-015 wb_en  in  1, wb_rd  in  REG_W  register-file write this cycle.
REQ-016 var_done  in  1  variable-latency pipe has a result ready; held high until granted.
REQ-017 var_wb_grant  out  1  the variable-latency result owns the WB port next cycle.
REQ-018 issue  out  1  instruction accepted this cycle.
REQ-019 sb_conflict, wb_conflict, var_busy  out  1 each  stall reasons.
REQ-020 pending  out  NUM_REGS  scoreboard bits, for debug.

Function
REQ-021 issue SHALL equal id_valid & ~stall & ~flush & ~sb_conflict & ~wb_conflict & ~(var_busy & id_pipe[VAR_PIPE]).
REQ-022 sb_conflict SHALL assert if any used operand (rs1, rs2, or rd when id_rd_we) has its pending bit set, unless bypassed by wb_en with a matching wb_rd (when ENABLE_BYPASS_WB=1); register x0 never conflicts.
REQ-023 The pending bit for register r SHALL clear on wb_en && wb_rd==r, and SHALL set on issue && id_rd_we && id_rd==r; set wins when both occur; x0 is never set.
REQ-024 The reservation vector resv[1..MAX_LAT] SHALL mean that resv[k]=1 reserves WB in cycle t+k.
REQ-025 Each cycle, resv[k] <= resv[k+1] | (issue & id_rd_we & L==k+1) for fixed pipe latency L; resv[MAX_LAT] <= 0.
REQ-026 wb_conflict SHALL assert for a fixed pipe of latency L>=2 with id_rd_we when resv[L]=1.
REQ-027 wb_conflict SHALL assert for L==1 when var_wb_grant=1.
REQ-028 var_wb_grant SHALL equal var_done & var_busy & ~resv[1]; the variable-latency result writes back in the cycle after the grant.
REQ-029 The variable-latency FSM SHALL have two states: IDLE->BUSY on issue to VAR_PIPE; BUSY->IDLE on var_wb_grant; var_busy=(state==BUSY).
REQ-030 Pipes other than VAR_PIPE SHALL continue issuing while BUSY, subject to REQ-021.
REQ-031 flush SHALL NOT alter pending, resv, or FSM state, because instructions already issued are older and complete normally.
REQ-032 Latency from issue to pending/resv visibility SHALL be one cycle; the stall outputs are combinational.

Reset
REQ-033 On rst, pending, resv and FSM state SHALL become 0/0/IDLE immediately; issue, var_wb_grant and all conflict outputs SHALL read 0 while rst is high.
REQ-034 Reset asserted mid-operation SHALL discard all reservations and leave no stale busy state.

Structure
REQ-035 The shared package SHALL hold the pipe index constants, the PIPE_LAT defaults, MAX_LAT and the FSM state enum.
REQ-036 The reservation shifter SHALL be one sub-module, wb_slot_tracker (parameter MAX_LAT), exposing resv and a one-hot reserve input.

Verification
REQ-037 After reset, issue pipe0 (L=1) rd=x5 -> pending[5]=1 next cycle; a dependent rs1=x5 gives sb_conflict=1 until the wb_en/wb_rd=5 cycle, where bypass gives issue=1.
REQ-038 Issue L=3 rd=x6 at t0, then L=1 rd=x7 at t1 -> issue=1; then L=2 at t1 rd=x8 -> wb_conflict=1 (slot t3 taken).
REQ-039 Issue VAR_PIPE, then a second VAR_PIPE request -> var_busy=1, issue=0; a concurrent pipe0 request -> issue=1.
REQ-040 var_done=1 while resv[1]=1 -> var_wb_grant=0; next cycle -> grant=1 and FSM returns to IDLE.
REQ-041 rst pulsed with pending=0x60 and resv nonzero -> all cleared asynchronously; rd=x0 issue never sets pending[0].
